// File: rtl/regfile_pkg.sv
// Shared types for the dual-write register file: clear-engine state encoding,
// default geometry and a write-request payload.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    // Write-port payload at the default geometry (pipeline writeback buses).
    typedef struct packed {
        logic                  en;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

endpackage : regfile_pkg

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks clr_ptr over every entry, one per cycle,
// then pulses clr_done. Requests are only accepted from IDLE.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] clr_ptr,
    output logic              clr_we
);

    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    clr_state_e        state_q;
    clr_state_e        state_d;
    logic [ADDR_W-1:0] ptr_d;

    // Next-state and pointer advance.
    always_comb begin
        state_d = state_q;
        ptr_d   = clr_ptr;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = clr_ptr + ADDR_W'(1);
                if (clr_ptr == LAST_PTR) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // State and flag registers; flags are decoded from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            clr_ptr  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            clr_we   <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_ptr  <= ptr_d;
            clr_busy <= (state_d == CLEAR);
            clr_done <= (state_d == DONE);
            clr_we   <= (state_d == CLEAR);
        end
    end

endmodule : regfile_clr_fsm

// File: rtl/regfile_2w2r.sv
// Two-read/two-write register file with a sequential clear engine.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_2w2r
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Read_addr_1,
    input  logic [ADDR_W-1:0] Read_addr_2,
    output logic [DATA_W-1:0] Read_data_1,
    output logic [DATA_W-1:0] Read_data_2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_addr,
    input  logic [DATA_W-1:0] Write_data,
    input  logic              RegWrite_2,
    input  logic [ADDR_W-1:0] Write_addr_2,
    input  logic [DATA_W-1:0] Write_data_2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NUM_REGS];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_ptr;
    logic              we1_ok_c;
    logic              we2_ok_c;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_ptr  (clr_ptr),
        .clr_we   (clr_we)
    );

    // A write aimed at the hardwired zero entry is not a real write at all.
    always_comb begin
        we1_ok_c = RegWrite   && !(ZERO_REG && (Write_addr   == '0));
        we2_ok_c = RegWrite_2 && !(ZERO_REG && (Write_addr_2 == '0));
    end

    // Storage: clear engine owns the array while running; otherwise port 2
    // is applied after port 1 so it wins on an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (we1_ok_c) begin
                mem[Write_addr] <= Write_data;
            end
            if (we2_ok_c) begin
                mem[Write_addr_2] <= Write_data_2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= clr_we && (we1_ok_c || we2_ok_c);
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0]  = Read_addr_1;
    assign rd_addr[1]  = Read_addr_2;
    assign Read_data_1 = rd_data[0];
    assign Read_data_2 = rd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rd_data[p] = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            // Writes discarded by the clear engine must not be forwarded.
            if (!clr_we) begin
                if (we1_ok_c && (Write_addr == rd_addr[p])) begin
                    rd_data[p] = Write_data;
                end
                if (we2_ok_c && (Write_addr_2 == rd_addr[p])) begin
                    rd_data[p] = Write_data_2;
                end
            end
`endif
            if (ZERO_REG && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end
        end
    end

endmodule : regfile_2w2r

// File: tb/tb_regfile_2w2r.sv
// Scoreboard bench for regfile_2w2r: stimulus queues expectations per cycle,
// a negedge monitor pops and compares them.
module tb_regfile_2w2r;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa1, wa2;
    logic [31:0] wd1, wd2;
    logic        we1, we2, clr_req;
    logic [31:0] rd1, rd2, rd1_z, rd2_z;
    logic        busy, done, drop, busy_z, done_z, drop_z;

    always #5 clk = ~clk;

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .Read_addr_1(ra1), .Read_addr_2(ra2),
        .Read_data_1(rd1), .Read_data_2(rd2),
        .RegWrite(we1), .Write_addr(wa1), .Write_data(wd1),
        .RegWrite_2(we2), .Write_addr_2(wa2), .Write_data_2(wd2),
        .clr_req(clr_req), .clr_busy(busy), .clr_done(done), .wr_drop(drop)
    );

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_z0 (
        .clk(clk), .rst(rst),
        .Read_addr_1(ra1), .Read_addr_2(ra2),
        .Read_data_1(rd1_z), .Read_data_2(rd2_z),
        .RegWrite(we1), .Write_addr(wa1), .Write_data(wd1),
        .RegWrite_2(we2), .Write_addr_2(wa2), .Write_data_2(wd2),
        .clr_req(clr_req), .clr_busy(busy_z), .clr_done(done_z), .wr_drop(drop_z)
    );

    localparam int S_RD1 = 0, S_RD2 = 1, S_BUSY = 2, S_DONE = 3, S_DROP = 4;
    localparam int S_RD1Z = 5, S_RD2Z = 6, S_BUSYZ = 7, S_DONEZ = 8, S_DROPZ = 9;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sample(input int s);
        case (s)
            S_RD1:   return rd1;
            S_RD2:   return rd2;
            S_BUSY:  return 32'(busy);
            S_DONE:  return 32'(done);
            S_DROP:  return 32'(drop);
            S_RD1Z:  return rd1_z;
            S_RD2Z:  return rd2_z;
            S_BUSYZ: return 32'(busy_z);
            S_DONEZ: return 32'(done_z);
            S_DROPZ: return 32'(drop_z);
            default: return 32'hDEAD_0BAD;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_RD1:   return "Read_data_1";
            S_RD2:   return "Read_data_2";
            S_BUSY:  return "clr_busy";
            S_DONE:  return "clr_done";
            S_DROP:  return "wr_drop";
            S_RD1Z:  return "z0.Read_data_1";
            S_RD2Z:  return "z0.Read_data_2";
            S_BUSYZ: return "z0.clr_busy";
            S_DONEZ: return "z0.clr_done";
            S_DROPZ: return "z0.wr_drop";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compare everything queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.cyc != cyc || sample(e.sig) !== e.val) begin
                n_miss++;
                $display("FAIL %s cyc %0d: got %h expected %h (checked at cyc %0d)",
                         sig_name(e.sig), e.cyc, sample(e.sig), e.val, cyc);
            end
        end
    end

    task automatic expect_val(input int s, input logic [31:0] v);
        sb.push_back('{cyc, s, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we1 = 1'b0; we2 = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ra1 = '0; ra2 = '0; wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
        idle_inputs();

        // Reset state
        tick();
        ra1 = 5'd5;
        expect_val(S_BUSY, 0); expect_val(S_DONE, 0); expect_val(S_DROP, 0);
        expect_val(S_BUSYZ, 0); expect_val(S_RD1, 0);
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            expect_val(S_RD1, 0); expect_val(S_RD2, 0); expect_val(S_RD1Z, 0);
            tick();
        end

        // Port 1 write, read back next cycle
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEAD_BEEF; ra1 = 5'd5;
        expect_val(S_RD1, BYP ? 32'hDEAD_BEEF : 32'h0);
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            n_miss++;
            $display("FAIL direct: addr 5 read %h expected DEADBEEF", rd1);
        end
        expect_val(S_RD1, 32'hDEAD_BEEF); expect_val(S_DROP, 0);
        tick();

        // Same-address collision: port 2 wins, no drop
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h1111;
        we2 = 1'b1; wa2 = 5'd9; wd2 = 32'h2222; ra2 = 5'd9;
        expect_val(S_RD2, BYP ? 32'h2222 : 32'h0);
        expect_val(S_RD1, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (rd2 !== 32'h2222 || drop !== 1'b0) begin
            n_miss++;
            $display("FAIL direct: collision read %h drop %b", rd2, drop);
        end
        expect_val(S_RD2, 32'h2222); expect_val(S_DROP, 0);
        tick();

        // Different addresses commit together
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h3333_3333;
        we2 = 1'b1; wa2 = 5'd4; wd2 = 32'h4444_4444; ra1 = 5'd3; ra2 = 5'd4;
        expect_val(S_RD1, BYP ? 32'h3333_3333 : 32'h0);
        expect_val(S_RD2, BYP ? 32'h4444_4444 : 32'h0);
        tick();
        idle_inputs();
        expect_val(S_RD1, 32'h3333_3333); expect_val(S_RD2, 32'h4444_4444);
        expect_val(S_DROP, 0);
        tick();
        expect_val(S_RD1, 32'h3333_3333); expect_val(S_RD2, 32'h4444_4444);
        tick();

        // Entry 0: hardwired with ZERO_REG=1, ordinary with ZERO_REG=0
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF; ra1 = 5'd0;
        expect_val(S_RD1, 0); expect_val(S_RD1Z, BYP ? 32'hFFFF : 32'h0);
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (rd1 !== 32'h0 || rd1_z !== 32'hFFFF) begin
            n_miss++;
            $display("FAIL direct: entry 0 read %h / z0 %h", rd1, rd1_z);
        end
        expect_val(S_RD1, 0); expect_val(S_RD1Z, 32'hFFFF);
        expect_val(S_DROP, 0); expect_val(S_DROPZ, 0);
        tick();

        // Same-cycle read of the address being written
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h1234;
        tick();
        wd1 = 32'hABCD; ra1 = 5'd7;
        expect_val(S_RD1, BYP ? 32'hABCD : 32'h1234);
        tick();
        idle_inputs();
        expect_val(S_RD1, 32'hABCD);
        tick();

        // Fill every entry
        for (int i = 0; i < 32; i++) begin
            we1 = 1'b1; wa1 = 5'(i); wd1 = 32'hA500_0000 | 32'(i);
            tick();
        end
        idle_inputs();
        ra1 = 5'd31; ra2 = 5'd0;
        expect_val(S_RD1, 32'hA500_001F); expect_val(S_RD2, 0);
        expect_val(S_RD2Z, 32'hA500_0000);
        tick();

        // Clear sweep with a dropped write at clear cycle 10
        clr_req = 1'b1;
        expect_val(S_BUSY, 0); expect_val(S_DONE, 0);
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            we1 = (k == 10); wa1 = 5'd3; wd1 = 32'h77;
            clr_req = (k == 20);
            ra1 = 5'(k);
            expect_val(S_BUSY, 1); expect_val(S_DONE, 0); expect_val(S_BUSYZ, 1);
            expect_val(S_RD1, (k == 0) ? 32'h0 : (32'hA500_0000 | 32'(k)));
            if (k > 0) begin
                ra2 = (k == 10) ? 5'd3 : 5'(k - 1);
                expect_val(S_RD2, 0);
            end
            expect_val(S_DROP, (k == 11) ? 32'h1 : 32'h0);
            tick();
        end
        idle_inputs();

        // DONE: pulse, clr_req ignored, writes commit
        clr_req = 1'b1; we1 = 1'b1; wa1 = 5'd20; wd1 = 32'h55;
        expect_val(S_BUSY, 0); expect_val(S_DONE, 1); expect_val(S_DONEZ, 1);
        expect_val(S_DROP, 0);
        tick();
        idle_inputs();
        expect_val(S_BUSY, 0); expect_val(S_DONE, 0);
        tick();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i);
            expect_val(S_RD1, (i == 20) ? 32'h55 : 32'h0);
            expect_val(S_RD2Z, (i == 20) ? 32'h55 : 32'h0);
            expect_val(S_BUSY, 0);
            tick();
        end

        // Reset at clear cycle 7 aborts the sweep
        we1 = 1'b1; wa1 = 5'd30; wd1 = 32'h3030;
        we2 = 1'b1; wa2 = 5'd12; wd2 = 32'h1212;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            expect_val(S_BUSY, 1);
            tick();
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_miss++;
            $display("FAIL direct: async reset busy %b done %b", busy, done);
        end
        expect_val(S_BUSY, 0); expect_val(S_DONE, 0); expect_val(S_BUSYZ, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            expect_val(S_RD1Z, 0); expect_val(S_RD2, 0);
            expect_val(S_BUSY, 0); expect_val(S_DONE, 0);
            tick();
        end

        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL %s cyc %0d: never checked, expected %h",
                     sig_name(e.sig), e.cyc, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_regfile_2w2r

// File: doc/regfile_2w2r.md
Name: regfile_2w2r

Overview:
- Parametrised successor to the single-write CPU register file.
- Two combinational read ports and two write ports: port 1 for ALU writeback, port 2 for load/late writeback.
- Built-in sequential clear engine: zeroes the whole array one entry per cycle on request, without asserting reset, with a busy/done handshake.
- Sits between decode (reads) and writeback (writes) in the single-cycle MIPS datapath. Also usable in a later pipelined core.

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W, derived, not overridable.
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores all writes; when 0 entry 0 is an ordinary register.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- Read_addr_1  input  ADDR_W  read port 1 address.
- Read_addr_2  input  ADDR_W  read port 2 address.
- Read_data_1  output  DATA_W  read port 1 data, combinational.
- Read_data_2  output  DATA_W  read port 2 data, combinational.
- RegWrite  input  1  write enable, port 1.
- Write_addr  input  ADDR_W  write address, port 1.
- Write_data  input  DATA_W  write data, port 1.
- RegWrite_2  input  1  write enable, port 2.
- Write_addr_2  input  ADDR_W  write address, port 2.
- Write_data_2  input  DATA_W  write data, port 2.
- clr_req  input  1  single-cycle clear request.
- clr_busy  output  1  high while the clear engine runs.
- clr_done  output  1  one-cycle pulse when the clear completes.
- wr_drop  output  1  one-cycle pulse: at least one enabled write was discarded.

Behaviour:
Reset (rst=0, asynchronous):
- All entries become 0; FSM goes to IDLE; clr_ptr=0.
- clr_busy=0, clr_done=0, wr_drop=0.
- Reset asserted mid-clear aborts the clear. No clr_done is issued.

Writes:
- Writes commit on the rising clk edge after enable is sampled high. Read-back latency is 1 cycle.
- A write to entry 0 is silently ignored when ZERO_REG=1. This does not raise wr_drop.
- Both ports enabled to the same address: port 2 wins, and the port 1 data is lost. wr_drop is not raised, because this is a defined priority.
- Both ports enabled to different addresses: both commit in the same cycle.

Reads:
- Read_data_x = array[Read_addr_x].
- Forced to 0 when the address is 0 and ZERO_REG=1.

Clear FSM, states IDLE, CLEAR, DONE:
- IDLE: when clr_req=1, go to CLEAR with clr_ptr=0.
- CLEAR: clr_busy=1. Each cycle, array[clr_ptr]<=0 and clr_ptr increments. When clr_ptr==NUM_REGS-1, go to DONE. The clear takes exactly NUM_REGS cycles.
- DONE: clr_done=1 for one cycle, clr_busy=0, then go to IDLE.
- clr_req is ignored while in CLEAR or DONE.
- clr_ptr wraps to 0 naturally at ADDR_W bits.

Writes while the clear engine is active (CLEAR and DONE states):
- In CLEAR, all port writes are discarded. wr_drop pulses high in the following cycle if either write enable was high (excluding the ZERO_REG case).
- In DONE, writes commit normally.
- Reads during CLEAR return the current array contents: already-cleared entries read 0, the rest read their old values.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If a read address equals an enabled write address, the read returns that write's data combinationally in the same cycle. Port 2 data takes priority when both ports match.
  - Forwarding is disabled for entry 0 when ZERO_REG=1.
  - Forwarding is disabled in the CLEAR state, since those writes are discarded.
- Not defined: reads return the pre-write array value in the write cycle. The new value is visible the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - the clear-FSM state enum (IDLE/CLEAR/DONE);
  - default DATA_W/ADDR_W localparams;
  - an optional write-request struct {en, addr, data}.
- One natural sub-module, regfile_clr_fsm:
  - inputs clk, rst, clr_req;
  - outputs clr_busy, clr_done, clr_ptr, clr_we.
  - The array, write arbitration and bypass stay in the top module.

Test Plan:
- Reset, then read all addresses → all 0. Write port 1 with addr 5 = 0xDEADBEEF → Read_data_1 at addr 5 returns 0xDEADBEEF on the next cycle.
- Same cycle, port 1 and port 2 both write addr 9 (0x1111 and 0x2222) → addr 9 reads 0x2222 and wr_drop=0. A same-cycle write to addr 3 and addr 4 → both values persist.
- Write 0xFFFF to addr 0 with ZERO_REG=1 → reads 0. Repeat with ZERO_REG=0 → reads 0xFFFF.
- Fill all 32 entries with a nonzero value, pulse clr_req → clr_busy high for exactly 32 cycles, clr_done pulses once, all entries read 0. A port 1 write issued at clear cycle 10 → dropped, wr_drop pulses once.
- Drop rst to 0 at clear cycle 7 → clr_busy=0 immediately, no clr_done, all entries 0 after rst returns to 1.
- With REGFILE_BYPASS_EN, write addr 7 = 0xABCD while reading addr 7 → Read_data_1=0xABCD in the same cycle. Without the macro → the old value in that cycle, 0xABCD on the next cycle.
